// File: rtl/cpu_pkg.sv
// Shared CPU constants: fetch-sequencer state encoding and IF-block defaults.
package cpu_pkg;

   // Sizes shared with the IF block
   localparam int unsigned WIDTH_B_DEF   = 32;
   localparam int unsigned ADDR_B_DEF    = 10;
   localparam int unsigned DRAIN_CYC_DEF = 4;
   localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

   // run_cycles counter width
   localparam int unsigned RUN_CNT_W = 32;

   // Fetch sequencer states (plain constants so legacy tools can read them)
   localparam logic [2:0] ST_BOOT   = 3'd0;
   localparam logic [2:0] ST_RUN    = 3'd1;
   localparam logic [2:0] ST_DRAIN  = 3'd2;
   localparam logic [2:0] ST_HALTED = 3'd3;
   localparam logic [2:0] ST_STEP   = 3'd4;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-control bundle between the sequencer and hazard/ID/EX/debug/IF logic.
interface fetch_sequencer_if #(
   parameter int unsigned width_B = 32
);
   logic [width_B-1:0] pc_current;
   logic               stall;
   logic               jump;
   logic [width_B-1:0] jump_target;
   logic               branch_taken;
   logic [width_B-1:0] branch_target;
   logic               halt_instr;
   logic               dbg_halt;
   logic               dbg_run;
   logic               dbg_step;
   logic [width_B-1:0] pc_next;
   logic               pc_write;
   logic               ifid_write;
   logic               flush_ifid;
   logic               flush_idex;
   logic               halted;
   logic [31:0]        run_cycles;

   // Sequencer side
   modport master (
      input  pc_current, stall, jump, jump_target, branch_taken, branch_target,
             halt_instr, dbg_halt, dbg_run, dbg_step,
      output pc_next, pc_write, ifid_write, flush_ifid, flush_idex, halted, run_cycles
   );

   // Surrounding pipeline / debugger side
   modport slave (
      output pc_current, stall, jump, jump_target, branch_taken, branch_target,
             halt_instr, dbg_halt, dbg_run, dbg_step,
      input  pc_next, pc_write, ifid_write, flush_ifid, flush_idex, halted, run_cycles
   );

endinterface

// File: rtl/fetch_sequencer_next_pc_mux.sv
// Next-PC priority select for a running cycle: branch (EX) > jump (ID) > stall > sequential.
// Result is masked to the instruction-memory address range.
module next_pc_mux #(
   parameter int unsigned width_B = 32,
   parameter int unsigned Addr_B  = 10
)(
   input  logic [width_B-1:0] i_pc_current,
   input  logic               i_stall,
   input  logic               i_jump,
   input  logic [width_B-1:0] i_jump_target,
   input  logic               i_branch_taken,
   input  logic [width_B-1:0] i_branch_target,
   output logic [width_B-1:0] o_pc_next,
   output logic               o_pc_write,
   output logic               o_ifid_write,
   output logic               o_flush_ifid,
   output logic               o_flush_idex
);

   localparam logic [width_B-1:0] ADDR_MASK = width_B'((64'd1 << Addr_B) - 64'd1);

   logic [width_B-1:0] w_raw_pc;

   // EX branch is older than the ID jump, so it wins over jump and stall
   always_comb begin
      w_raw_pc     = i_pc_current + width_B'(1);
      o_pc_write   = 1'b1;
      o_ifid_write = 1'b1;
      o_flush_ifid = 1'b0;
      o_flush_idex = 1'b0;
      if (i_branch_taken) begin
         w_raw_pc     = i_branch_target;
         o_flush_ifid = 1'b1;
         o_flush_idex = 1'b1;
      end else if (i_jump) begin
         w_raw_pc     = i_jump_target;
         o_flush_ifid = 1'b1;
      end else if (i_stall) begin
         o_pc_write   = 1'b0;
         o_ifid_write = 1'b0;
      end
   end

   // Sequential wrap at the top of memory falls out of the mask
   assign o_pc_next = w_raw_pc & ADDR_MASK;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: boot, run, halt drain and debug run/step/halt control.
// All fetch-control outputs are combinational from state and inputs (0-cycle redirect).
module fetch_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned        width_B   = WIDTH_B_DEF,
   parameter int unsigned        Addr_B    = ADDR_B_DEF,
   parameter int unsigned        DRAIN_CYC = DRAIN_CYC_DEF,
   parameter logic [width_B-1:0] RESET_PC  = width_B'(RESET_PC_DEF)
)(
   input  logic              clk,
   input  logic              rst_n,
   fetch_sequencer_if.master io_bus
);

   localparam logic [width_B-1:0] ADDR_MASK  = width_B'((64'd1 << Addr_B) - 64'd1);
   localparam int unsigned        CNT_W      = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);
   localparam logic [CNT_W-1:0]   DRAIN_LOAD = CNT_W'(DRAIN_CYC);

   // Saturating increment for the run-cycle counter
   function automatic logic [RUN_CNT_W-1:0] sat_inc(input logic [RUN_CNT_W-1:0] v);
      return (&v) ? v : v + RUN_CNT_W'(1);
   endfunction

   logic [2:0]           r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [RUN_CNT_W-1:0] r_run_cycles;

   logic [2:0]           w_state_nxt;
   logic [CNT_W-1:0]     w_cnt_nxt;
   logic                 w_halt_req;

   logic [width_B-1:0]   w_mux_pc_next;
   logic                 w_mux_pc_write;
   logic                 w_mux_ifid_write;
   logic                 w_mux_flush_ifid;
   logic                 w_mux_flush_idex;

   logic [width_B-1:0]   w_pc_next;
   logic                 w_pc_write;
   logic                 w_ifid_write;
   logic                 w_flush_ifid;
   logic                 w_flush_idex;
   logic                 w_halted;

   next_pc_mux #(
      .width_B (width_B),
      .Addr_B  (Addr_B)
   ) u_next_pc_mux (
      .i_pc_current    (io_bus.pc_current),
      .i_stall         (io_bus.stall),
      .i_jump          (io_bus.jump),
      .i_jump_target   (io_bus.jump_target),
      .i_branch_taken  (io_bus.branch_taken),
      .i_branch_target (io_bus.branch_target),
      .o_pc_next       (w_mux_pc_next),
      .o_pc_write      (w_mux_pc_write),
      .o_ifid_write    (w_mux_ifid_write),
      .o_flush_ifid    (w_mux_flush_ifid),
      .o_flush_idex    (w_mux_flush_idex)
   );

   // A halt (opcode or debugger) only takes effect when the ID instruction is real and not squashed
   assign w_halt_req = (io_bus.halt_instr | io_bus.dbg_halt) & ~io_bus.stall & ~io_bus.branch_taken;

   // State decode: fetch-control outputs and next state/drain count
   always_comb begin
      w_pc_next    = io_bus.pc_current & ADDR_MASK;
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_flush_ifid = 1'b0;
      w_flush_idex = 1'b0;
      w_halted     = 1'b0;
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      case (r_state)
         ST_BOOT: begin
            w_pc_next    = RESET_PC & ADDR_MASK;
            w_pc_write   = 1'b1;
            w_ifid_write = 1'b1;
            w_flush_ifid = 1'b1;
            w_state_nxt  = io_bus.dbg_halt ? ST_HALTED : ST_RUN;
         end
         ST_RUN, ST_STEP: begin
            w_pc_next    = w_mux_pc_next;
            w_pc_write   = w_mux_pc_write;
            w_ifid_write = w_mux_ifid_write;
            w_flush_ifid = w_mux_flush_ifid;
            w_flush_idex = w_mux_flush_idex;
            if (w_halt_req) begin
               w_pc_write   = 1'b0;
               w_ifid_write = 1'b0;
               w_flush_ifid = 1'b1;
               w_state_nxt  = ST_DRAIN;
               w_cnt_nxt    = DRAIN_LOAD;
            end else if (r_state == ST_STEP) begin
               w_state_nxt  = ST_DRAIN;
               w_cnt_nxt    = DRAIN_LOAD;
            end
         end
         ST_DRAIN: begin
            w_flush_ifid = 1'b1;
            w_cnt_nxt    = r_cnt - CNT_W'(1);
            // Last drain cycle when the count is about to reach zero
            if (r_cnt <= CNT_W'(1)) begin
               w_cnt_nxt   = '0;
               w_state_nxt = ST_HALTED;
            end
         end
         ST_HALTED: begin
            w_halted     = 1'b1;
            w_flush_ifid = 1'b1;
            if (io_bus.dbg_step) begin
               w_state_nxt = ST_STEP;
            end else if (io_bus.dbg_run && !io_bus.dbg_halt) begin
               // Refetch the instruction the halt squashed, then run normally
               w_pc_write   = 1'b1;
               w_ifid_write = 1'b1;
               w_state_nxt  = ST_RUN;
            end
         end
         default: begin
            w_state_nxt = ST_BOOT;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // FSM state and drain counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_BOOT;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Count cycles that actually advance the PC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run_cycles <= '0;
      end else if (w_pc_write) begin
         r_run_cycles <= sat_inc(r_run_cycles);
      end
   end

   // Reset forces quiet outputs immediately, without waiting for a clock
   assign io_bus.pc_next    = rst_n ? w_pc_next : RESET_PC;
   assign io_bus.pc_write   = rst_n & w_pc_write;
   assign io_bus.ifid_write = rst_n & w_ifid_write;
   assign io_bus.flush_ifid = rst_n & w_flush_ifid;
   assign io_bus.flush_idex = rst_n & w_flush_idex;
   assign io_bus.halted     = rst_n & w_halted;
   assign io_bus.run_cycles = r_run_cycles;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: boot, stall, redirect priority, wrap, halt/step/run, async reset.
module tb_fetch_sequencer;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   int   pulses;

   fetch_sequencer_if #(.width_B(32)) bus ();

   fetch_sequencer #(
      .width_B   (32),
      .Addr_B    (10),
      .DRAIN_CYC (4),
      .RESET_PC  (32'h0)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are then changed 1 ns after the edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      pulses   = 0;
      rst_n              = 1'b0;
      bus.pc_current     = '0;
      bus.stall          = 1'b0;
      bus.jump           = 1'b0;
      bus.jump_target    = '0;
      bus.branch_taken   = 1'b0;
      bus.branch_target  = '0;
      bus.halt_instr     = 1'b0;
      bus.dbg_halt       = 1'b0;
      bus.dbg_run        = 1'b0;
      bus.dbg_step       = 1'b0;

      // Reset state
      #1;
      chk1 ("rst_pc_write",   bus.pc_write,   1'b0);
      chk1 ("rst_ifid_write", bus.ifid_write, 1'b0);
      chk1 ("rst_flush_ifid", bus.flush_ifid, 1'b0);
      chk1 ("rst_flush_idex", bus.flush_idex, 1'b0);
      chk1 ("rst_halted",     bus.halted,     1'b0);
      chk32("rst_pc_next",    bus.pc_next,    32'h0);
      chk32("rst_run_cycles", bus.run_cycles, 32'h0);
      cyc(); cyc();

      // Release: BOOT cycle fetches RESET_PC
      rst_n = 1'b1;
      #1;
      chk1 ("boot_pc_write",   bus.pc_write,   1'b1);
      chk32("boot_pc_next",    bus.pc_next,    32'h0);
      chk1 ("boot_flush_ifid", bus.flush_ifid, 1'b1);
      cyc();

      // Sequential 1,2,3
      bus.pc_current = 32'd0; #1;
      chk32("seq_pc1", bus.pc_next, 32'd1);
      chk1 ("seq_flush1", bus.flush_ifid, 1'b0);
      cyc();
      bus.pc_current = 32'd1; #1;
      chk32("seq_pc2", bus.pc_next, 32'd2);
      cyc();
      bus.pc_current = 32'd2; #1;
      chk32("seq_pc3", bus.pc_next, 32'd3);
      cyc();

      // Two-cycle stall at pc 5
      bus.pc_current = 32'd5;
      bus.stall = 1'b1; #1;
      chk1 ("stall1_pc_write",   bus.pc_write,   1'b0);
      chk1 ("stall1_ifid_write", bus.ifid_write, 1'b0);
      chk32("stall1_run_cycles", bus.run_cycles, 32'd4);
      cyc();
      #1;
      chk1 ("stall2_pc_write",   bus.pc_write,   1'b0);
      chk1 ("stall2_ifid_write", bus.ifid_write, 1'b0);
      cyc();
      bus.stall = 1'b0; #1;
      chk32("post_stall_pc",    bus.pc_next,  32'd6);
      chk1 ("post_stall_write", bus.pc_write, 1'b1);
      chk32("post_stall_run",   bus.run_cycles, 32'd4);
      cyc();

      // Branch + jump + stall together: branch wins
      bus.pc_current    = 32'd6;
      bus.branch_taken  = 1'b1;
      bus.branch_target = 32'h40;
      bus.jump          = 1'b1;
      bus.jump_target   = 32'h80;
      bus.stall         = 1'b1; #1;
      chk32("prio_pc_next",    bus.pc_next,    32'h40);
      chk1 ("prio_pc_write",   bus.pc_write,   1'b1);
      chk1 ("prio_flush_ifid", bus.flush_ifid, 1'b1);
      chk1 ("prio_flush_idex", bus.flush_idex, 1'b1);
      cyc();

      // Jump alone flushes only IF/ID
      bus.branch_taken = 1'b0;
      bus.stall        = 1'b0; #1;
      chk32("jump_pc_next",    bus.pc_next,    32'h80);
      chk1 ("jump_flush_ifid", bus.flush_ifid, 1'b1);
      chk1 ("jump_flush_idex", bus.flush_idex, 1'b0);
      cyc();

      // Wrap at top of memory, and masked jump target
      bus.jump       = 1'b0;
      bus.pc_current = 32'd1023; #1;
      chk32("wrap_pc_next", bus.pc_next, 32'h0);
      cyc();
      bus.jump        = 1'b1;
      bus.jump_target = 32'h1405; #1;
      chk32("mask_jump_pc", bus.pc_next, 32'h005);
      cyc();
      bus.jump = 1'b0;

      // halt_instr under stall is ignored
      bus.pc_current = 32'h10;
      bus.stall      = 1'b1;
      bus.halt_instr = 1'b1; #1;
      chk1 ("halt_stall_write", bus.pc_write,   1'b0);
      chk1 ("halt_stall_flush", bus.flush_ifid, 1'b0);
      cyc();
      bus.stall      = 1'b0;
      bus.halt_instr = 1'b0; #1;
      chk1 ("halt_ignored_run", bus.pc_write, 1'b1);
      chk32("halt_ignored_pc",  bus.pc_next,  32'h11);
      cyc();

      // Halt at cycle t: pc_write drops at t, halted at t+5
      bus.pc_current = 32'h11;
      bus.halt_instr = 1'b1; #1;
      chk1 ("halt_t_write", bus.pc_write,   1'b0);
      chk1 ("halt_t_flush", bus.flush_ifid, 1'b1);
      cyc();
      bus.halt_instr = 1'b0; #1;
      chk1 ("drain_write",  bus.pc_write,   1'b0);
      chk1 ("drain_ifid",   bus.ifid_write, 1'b0);
      chk1 ("drain_flush",  bus.flush_ifid, 1'b1);
      chk1 ("drain_halted", bus.halted,     1'b0);
      cyc(); cyc(); cyc();
      chk1 ("drain_t4_halted", bus.halted, 1'b0);
      cyc();
      chk1 ("halted_t5",        bus.halted,     1'b1);
      chk1 ("halted_pc_write",  bus.pc_write,   1'b0);
      chk1 ("halted_flush",     bus.flush_ifid, 1'b1);
      chk32("halted_run_cycles", bus.run_cycles, 32'd10);

      // Single step: one fetch, then drain back to halted
      bus.pc_current = 32'h12;
      bus.dbg_step   = 1'b1; #1;
      chk1 ("step_req_write", bus.pc_write, 1'b0);
      cyc();
      bus.dbg_step = 1'b0; #1;
      chk1 ("step_write",  bus.pc_write, 1'b1);
      chk32("step_pc",     bus.pc_next,  32'h13);
      chk1 ("step_halted", bus.halted,   1'b0);
      cyc();
      for (int i = 0; i < 4; i++) begin
         pulses = pulses + int'(bus.pc_write);
         chk1 ("step_drain_halted", bus.halted, 1'b0);
         cyc();
      end
      chk32("step_extra_pulses", 32'(pulses), 32'd0);
      chk1 ("step_rehalted",     bus.halted,   1'b1);
      chk32("step_run_cycles",   bus.run_cycles, 32'd11);

      // Resume at pc_current
      bus.pc_current = 32'h13;
      bus.dbg_run    = 1'b1; #1;
      chk1 ("resume_write", bus.pc_write, 1'b1);
      chk32("resume_pc",    bus.pc_next,  32'h13);
      cyc();
      bus.dbg_run = 1'b0; #1;
      chk32("resume_run_pc",  bus.pc_next,    32'h14);
      chk1 ("resume_halted",  bus.halted,     1'b0);
      chk32("resume_run_cnt", bus.run_cycles, 32'd12);
      cyc();

      // Debug halt in RUN, then async reset with drain counter at 2
      bus.pc_current = 32'h14;
      bus.dbg_halt   = 1'b1; #1;
      chk1 ("dbg_halt_write", bus.pc_write, 1'b0);
      cyc();
      bus.dbg_halt = 1'b0;
      cyc(); cyc();
      chk1 ("dbg_drain_flush", bus.flush_ifid, 1'b1);
      rst_n = 1'b0; #1;
      chk1 ("arst_pc_write",   bus.pc_write,   1'b0);
      chk1 ("arst_flush_ifid", bus.flush_ifid, 1'b0);
      chk1 ("arst_halted",     bus.halted,     1'b0);
      chk32("arst_pc_next",    bus.pc_next,    32'h0);
      chk32("arst_run_cycles", bus.run_cycles, 32'h0);
      cyc();

      // dbg_halt held through BOOT goes straight to HALTED
      rst_n        = 1'b1;
      bus.dbg_halt = 1'b1; #1;
      chk1 ("boot2_pc_write", bus.pc_write, 1'b1);
      cyc();
      chk1 ("boot_halt_halted", bus.halted, 1'b1);
      bus.dbg_run = 1'b1; #1;
      chk1 ("run_blocked_write", bus.pc_write, 1'b0);
      cyc();

      // run and step together: step wins
      bus.dbg_halt   = 1'b0;
      bus.dbg_step   = 1'b1;
      bus.pc_current = 32'h0; #1;
      chk1 ("run_step_write", bus.pc_write, 1'b0);
      cyc();
      bus.dbg_run  = 1'b0;
      bus.dbg_step = 1'b0; #1;
      chk1 ("run_step_stepped", bus.pc_write, 1'b1);
      chk32("run_step_pc",      bus.pc_next,  32'h1);
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
